// File: rtl/multicycle_control.sv
// Control FSM for the multicycle RV32I core: sequences FETCH/DECODE/execute steps
// and drives every datapath control input from the current state and the IR fields.
module multicycle_control #(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSel,
  output logic [3:0] ALUControl,
  output logic [1:0] ResultSrc,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC <= PC+4
  // DECODE   | ALUOut <= OldPC + imm (branch/jump target)
  // MEMADR   | ALUOut <= rs1 + imm
  // MEMREAD  | read data memory at ALUOut
  // MEMWB    | rd <= Data
  // MEMWRITE | write rs2 to data memory at ALUOut
  // EXEC_R   | ALUOut <= rs1 op rs2
  // EXEC_I   | ALUOut <= rs1 op imm
  // ALUWB    | rd <= ALUOut
  // BRANCH   | compare rs1/rs2, PC <= ALUOut when taken
  // JAL      | PC <= ALUOut, ALUOut <= OldPC+4
  // LUI      | ALUOut <= U-immediate
  // TRAP     | halted on an unsupported opcode until reset
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_SLT = 4'd8, ALU_SLTU = 4'd9, ALU_PASSB = 4'd10;

  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;

  state_t state_q, state_d;
  logic   pc_write_c, mem_write_c, ir_write_c, reg_write_c, done_c, illegal_c;

  // funct7_b5 only turns ADD into SUB for register-register ops; SRA/SRAI always honour it
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic b5, input logic is_r);
    case (f3)
      3'b000:  alu_decode = (is_r && b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_decode = ALU_SLL;
      3'b010:  alu_decode = ALU_SLT;
      3'b011:  alu_decode = ALU_SLTU;
      3'b100:  alu_decode = ALU_XOR;
      3'b101:  alu_decode = b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_decode = ALU_OR;
      default: alu_decode = ALU_AND;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pc_write_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    done_c      = 1'b0;
    illegal_c   = 1'b0;
    AdrSrc      = 1'b0;
    ALUSrcA     = 2'd0;
    ALUSrcB     = 2'd0;
    ImmSel      = IMM_I;
    ALUControl  = ALU_ADD;
    ResultSrc   = 2'd0;
    case (state_q)
      S_FETCH: begin
        ir_write_c = 1'b1;
        pc_write_c = 1'b1;
        ALUSrcB    = 2'd2;
        ResultSrc  = 2'd2;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd1;
        if (opcode == OP_BR)       ImmSel = IMM_B;
        else if (opcode == OP_JAL) ImmSel = IMM_J;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          OP_LUI:       state_d = S_LUI;
          default: begin
            if (TRAP_ON_ILLEGAL) begin
              state_d = S_TRAP;
            end else begin
              state_d = S_FETCH;
              done_c  = 1'b1;
            end
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'd2;
        ALUSrcB = 2'd1;
        ImmSel  = (opcode == OP_SW) ? IMM_S : IMM_I;
        state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc   = 2'd1;
        reg_write_c = 1'b1;
        done_c      = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_c = 1'b1;
        done_c      = 1'b1;
        state_d     = S_FETCH;
      end
      S_EXEC_R: begin
        ALUSrcA    = 2'd2;
        ALUControl = alu_decode(funct3, funct7_b5, 1'b1);
        state_d    = S_ALUWB;
      end
      S_EXEC_I: begin
        ALUSrcA    = 2'd2;
        ALUSrcB    = 2'd1;
        ALUControl = alu_decode(funct3, funct7_b5, 1'b0);
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        done_c      = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'd2;
        ALUControl = ALU_SUB;
        if (funct3 == 3'b000)      pc_write_c = zero;
        else if (funct3 == 3'b001) pc_write_c = ~zero;
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA    = 2'd1;
        ALUSrcB    = 2'd2;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcB    = 2'd1;
        ImmSel     = IMM_U;
        ALUControl = ALU_PASSB;
        state_d    = S_ALUWB;
      end
      S_TRAP: begin
        illegal_c = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset masks every side effect so an aborted instruction leaves no trace
  assign PCWrite    = pc_write_c  & ~reset;
  assign MemWrite   = mem_write_c & ~reset;
  assign IRWrite    = ir_write_c  & ~reset;
  assign RegWrite   = reg_write_c & ~reset;
  assign instr_done = done_c      & ~reset;
  assign illegal    = illegal_c   & ~reset;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level reference model (state walk, write
// side effects, ALU semantics) compared every cycle against a trapping and a NOP-mode DUT.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       funct7_b5 = 1'b0;
  logic       zero = 1'b0;

  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ImmSel;
  logic [3:0] ALUControl, state;

  logic n_PCWrite, n_AdrSrc, n_MemWrite, n_IRWrite, n_RegWrite, n_instr_done, n_illegal;
  logic [1:0] n_ALUSrcA, n_ALUSrcB, n_ResultSrc;
  logic [2:0] n_ImmSel;
  logic [3:0] n_ALUControl, n_state;

  int n_vec = 0;
  int n_bad = 0;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BR = 4, C_JAL = 5, C_LUI = 6, C_ILL = 7;

  multicycle_control #(.TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_b5(funct7_b5),
    .zero(zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSel(ImmSel),
    .ALUControl(ALUControl), .ResultSrc(ResultSrc), .instr_done(instr_done),
    .illegal(illegal), .state(state)
  );

  multicycle_control #(.TRAP_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_b5(funct7_b5),
    .zero(zero), .PCWrite(n_PCWrite), .AdrSrc(n_AdrSrc), .MemWrite(n_MemWrite),
    .IRWrite(n_IRWrite), .RegWrite(n_RegWrite), .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB),
    .ImmSel(n_ImmSel), .ALUControl(n_ALUControl), .ResultSrc(n_ResultSrc),
    .instr_done(n_instr_done), .illegal(n_illegal), .state(n_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int classify(input logic [6:0] op);
    case (op)
      7'b0000011: return C_LW;
      7'b0100011: return C_SW;
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b1100011: return C_BR;
      7'b1101111: return C_JAL;
      7'b0110111: return C_LUI;
      default:    return C_ILL;
    endcase
  endfunction

  // Datapath ALU behaviour implied by each ALUControl code
  function automatic logic [31:0] alu_eval(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
    case (ctl)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << b[4:0];
      4'd6:  return a >> b[4:0];
      4'd7:  return $unsigned($signed(a) >>> b[4:0]);
      4'd8:  return {31'd0, $signed(a) < $signed(b)};
      4'd9:  return {31'd0, a < b};
      4'd10: return b;
      default: return 32'hdead_beef;
    endcase
  endfunction

  // Architectural result of the R/I-type instruction
  function automatic logic [31:0] isa_eval(input logic [2:0] f3, input logic b5, input bit is_r,
                                           input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return (is_r && b5) ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return {31'd0, $signed(a) < $signed(b)};
      3'd3: return {31'd0, a < b};
      3'd4: return a ^ b;
      3'd5: return b5 ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic void state_walk(input int c, input bit nop_mode, output int seq[$]);
    case (c)
      C_LW:   seq = '{0, 1, 2, 3, 4};
      C_SW:   seq = '{0, 1, 2, 5};
      C_R:    seq = '{0, 1, 6, 8};
      C_I:    seq = '{0, 1, 7, 8};
      C_BR:   seq = '{0, 1, 9};
      C_JAL:  seq = '{0, 1, 10, 8};
      C_LUI:  seq = '{0, 1, 11, 8};
      default: if (nop_mode) seq = '{0, 1}; else seq = '{0, 1, 12};
    endcase
  endfunction

  // {SrcA, SrcB} that each step of an instruction must present
  function automatic logic [3:0] exp_src(input int st);
    case (st)
      0: return {2'd0, 2'd2};
      1: return {2'd1, 2'd1};
      2: return {2'd2, 2'd1};
      6: return {2'd2, 2'd0};
      7: return {2'd2, 2'd1};
      9: return {2'd2, 2'd0};
      10: return {2'd1, 2'd2};
      11: return {2'd0, 2'd1};
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [2:0] exp_imm(input int st, input int c);
    if (st == 1) return (c == C_BR) ? 3'd2 : (c == C_JAL) ? 3'd4 : 3'd0;
    if (st == 2) return (c == C_SW) ? 3'd1 : 3'd0;
    if (st == 11) return 3'd3;
    return 3'd0;
  endfunction

  task automatic run_instr(input logic [31:0] ir, input bit z, input bit nop_dut, input string name);
    int c, n, st;
    int seq[$];
    bit done, taken;
    logic [19:0] expv, actv;
    logic [3:0] ctl;
    logic [31:0] a, b;
    c = classify(ir[6:0]);
    opcode = ir[6:0]; funct3 = ir[14:12]; funct7_b5 = ir[30]; zero = z;
    state_walk(c, nop_dut, seq);
    n = seq.size();
    taken = (ir[14:12] == 3'd0) ? z : (ir[14:12] == 3'd1) ? !z : 1'b0;
    for (int k = 0; k < n; k++) begin
      #1;
      st = seq[k];
      done = (k == n - 1) && !(c == C_ILL && !nop_dut);
      expv = {st[3:0],
              (k == 0) || (st == 10) || (st == 9 && taken),
              k == 0,
              done && (c inside {C_LW, C_R, C_I, C_JAL, C_LUI}),
              done && (c == C_SW),
              (c == C_LW || c == C_SW) && k == 3,
              done,
              st == 12,
              (k == 0) ? 2'd2 : (c == C_LW && k == 4) ? 2'd1 : 2'd0,
              exp_src(st),
              exp_imm(st, c)};
      if (nop_dut)
        actv = {n_state, n_PCWrite, n_IRWrite, n_RegWrite, n_MemWrite, n_AdrSrc, n_instr_done,
                n_illegal, n_ResultSrc, n_ALUSrcA, n_ALUSrcB, n_ImmSel};
      else
        actv = {state, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, instr_done,
                illegal, ResultSrc, ALUSrcA, ALUSrcB, ImmSel};
      ctl = nop_dut ? n_ALUControl : ALUControl;
      n_vec++;
      if (actv !== expv) begin
        n_bad++;
        $display("FAIL %s step %0d: controls got %b want %b", name, k, actv, expv);
      end
      a = $urandom | 32'h8000_0000;
      b = ($urandom & 32'h7fff_ffff) | 32'd1;
      n_vec++;
      if (st == 6 || st == 7) begin
        if (alu_eval(ctl, a, b) !== isa_eval(ir[14:12], ir[30], st == 6, a, b)) begin
          n_bad++;
          $display("FAIL %s alu_op: ALUControl %0d gives %h want %h", name, ctl,
                   alu_eval(ctl, a, b), isa_eval(ir[14:12], ir[30], st == 6, a, b));
        end
      end else begin
        if (ctl !== ((st == 9) ? 4'd1 : (st == 11) ? 4'd10 : 4'd0)) begin
          n_bad++;
          $display("FAIL %s alu_ctl step %0d: got %0d want %0d", name, k, ctl,
                   (st == 9) ? 1 : (st == 11) ? 10 : 0);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({state, PCWrite, IRWrite, MemWrite, RegWrite, instr_done, illegal} !== 10'd0) begin
        n_bad++;
        $display("FAIL reset_hold cycle %0d: got %b want 0", i,
                 {state, PCWrite, IRWrite, MemWrite, RegWrite, instr_done, illegal});
      end
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if ({state, PCWrite, IRWrite, ALUSrcA, ALUSrcB, ResultSrc} !== {4'd0, 1'b1, 1'b1, 2'd0, 2'd2, 2'd2}) begin
      n_bad++;
      $display("FAIL reset_release fetch: got %b want %b",
               {state, PCWrite, IRWrite, ALUSrcA, ALUSrcB, ResultSrc},
               {4'd0, 1'b1, 1'b1, 2'd0, 2'd2, 2'd2});
    end
  endtask

  task automatic test_directed();
    run_instr(32'h00A3_0333, 1'b0, 1'b0, "add");
    run_instr(32'h40A3_0333, 1'b0, 1'b0, "sub");
    run_instr(32'h0042_A303, 1'b0, 1'b0, "lw");
    run_instr(32'h0062_A223, 1'b0, 1'b0, "sw");
    run_instr(32'h0080_00EF, 1'b0, 1'b0, "jal");
    run_instr(32'h1234_52B7, 1'b0, 1'b0, "lui");
    run_instr(32'h4053_5313, 1'b0, 1'b0, "srai");
    run_instr(32'h4053_0313, 1'b0, 1'b0, "addi_b5");
  endtask

  task automatic test_branch();
    run_instr(32'h0020_8463, 1'b1, 1'b0, "beq_taken");
    run_instr(32'h0020_8463, 1'b0, 1'b0, "beq_not");
    run_instr(32'h0020_9463, 1'b1, 1'b0, "bne_not");
    run_instr(32'h0020_9463, 1'b0, 1'b0, "bne_taken");
    run_instr(32'h0020_C463, 1'b1, 1'b0, "blt_unsupported");
    // zero toggled within the BRANCH cycle must reach PCWrite without a clock
    opcode = 7'b1100011; funct3 = 3'd0; zero = 1'b0;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      zero = i[0];
      #1;
      n_vec++;
      if (PCWrite !== i[0]) begin
        n_bad++;
        $display("FAIL beq_comb_zero: PCWrite got %b want %b", PCWrite, i[0]);
      end
    end
    tick();
  endtask

  task automatic test_reset_abort();
    opcode = 7'b0000011; funct3 = 3'd2; funct7_b5 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #1;
    n_vec++;
    if ({state, RegWrite} !== {4'd4, 1'b1}) begin
      n_bad++;
      $display("FAIL abort_pre: state/RegWrite got %b want %b", {state, RegWrite}, {4'd4, 1'b1});
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if ({RegWrite, instr_done, PCWrite, MemWrite, IRWrite} !== 5'd0) begin
      n_bad++;
      $display("FAIL abort_mask: got %b want 0", {RegWrite, instr_done, PCWrite, MemWrite, IRWrite});
    end
    tick();
    reset = 1'b0;
    n_vec++;
    if (state !== 4'd0) begin
      n_bad++;
      $display("FAIL abort_state: got %0d want 0", state);
    end
    run_instr(32'h00A3_0333, 1'b0, 1'b0, "add_after_abort");
  endtask

  task automatic test_illegal_nop();
    run_instr(32'h0000_007F, 1'b0, 1'b1, "illegal_nop");
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_trap();
    run_instr(32'h0000_007F, 1'b0, 1'b0, "illegal_trap");
    for (int i = 0; i < 10; i++) begin
      opcode = 7'($urandom);
      #1;
      n_vec++;
      if ({state, illegal, PCWrite, IRWrite, MemWrite, RegWrite, instr_done} !== {4'd12, 1'b1, 5'd0}) begin
        n_bad++;
        $display("FAIL trap_hold cycle %0d: got %b want %b", i,
                 {state, illegal, PCWrite, IRWrite, MemWrite, RegWrite, instr_done}, {4'd12, 1'b1, 5'd0});
      end
      tick();
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if (illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL trap_reset_mask: illegal got %b want 0", illegal);
    end
    tick();
    reset = 1'b0;
    n_vec++;
    if (state !== 4'd0) begin
      n_bad++;
      $display("FAIL trap_clear: state got %0d want 0", state);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                            7'b1100011, 7'b1101111, 7'b0110111};
    logic [31:0] ir;
    for (int i = 0; i < 60; i++) begin
      ir = $urandom;
      ir[6:0] = ops[$urandom_range(0, 6)];
      run_instr(ir, 1'($urandom), i[0], $sformatf("rand%0d_%h", i, ir));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_branch();
    test_reset_abort();
    test_illegal_nop();
    test_trap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
